// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: NCH producer lanes in, one registered consumer port out.
interface arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_sel;

  // slave: the mux itself; master: producers plus consumer around it
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_sel);
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_sel);
endinterface

// File: rtl/arb_mux.sv
// Registered NCH:1 mux with valid/ready and round-robin arbitration (1-cycle latency).
// Define ARB_MUX_FIXED_PRI_EN for fixed lowest-index-wins priority (no rotating pointer).
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic     clk,
  input  logic     rst_f,
  arb_mux_if.slave bus
);

  logic [NCH-1:0][WIDTH-1:0] lane_data;
  logic [NCH-1:0]            rdy;
  logic [WIDTH-1:0]          data_q;
  logic [SELW-1:0]           sel_q;
  logic [SELW-1:0]           win;
  logic                      win_vld;
  logic                      valid_q;
  logic                      load;
  logic                      xfer;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign load = ~valid_q | bus.out_ready;
  assign xfer = load & win_vld;

`ifdef ARB_MUX_FIXED_PRI_EN
  // Descending scan so the lowest requesting index is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        win_vld = 1'b1;
        win     = SELW'(i);
      end
    end
  end
`else
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] idx;

  // Descending offset scan: the requester closest to ptr is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = SELW'((int'(ptr) + k) % NCH);
      if (bus.in_valid[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end
`endif

  always_comb begin
    rdy = '0;
    if (rst_f && xfer) rdy[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
`ifndef ARB_MUX_FIXED_PRI_EN
      ptr     <= '0;
`endif
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= lane_data[win];
      sel_q   <= win;
`ifndef ARB_MUX_FIXED_PRI_EN
      ptr     <= (win == SELW'(NCH - 1)) ? '0 : win + SELW'(1);
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: reference model checked every cycle plus directed literal checks.
module tb_arb_mux;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic clk;
  logic rst_f;
  int   total = 0;
  int   bad   = 0;

  arb_mux_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: rotating-scan winner, state kept as plain ints.
  bit          m_init  = 0;
  bit          m_valid = 0;
  logic [31:0] m_data  = '0;
  int          m_sel   = 0;
  int          m_ptr   = 0;

  function automatic int pick(input logic [NCH-1:0] v, input int p);
`ifdef ARB_MUX_FIXED_PRI_EN
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NCH; k++) if (v[(p + k) % NCH]) return (p + k) % NCH;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] lane_word(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_f) begin
      m_init = 1; m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (m_init) begin
      g = pick(bus.in_valid, m_ptr);
      if ((!m_valid || bus.out_ready) && g >= 0) begin
        m_valid = 1; m_data = lane_word(g); m_sel = g; m_ptr = (g + 1) % NCH;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NCH-1:0] er;
    if (m_init) begin
      g  = pick(bus.in_valid, m_ptr);
      er = '0;
      if (rst_f && (!m_valid || bus.out_ready) && g >= 0) er[g] = 1'b1;
      chk("model_in_ready", 64'(bus.in_ready), 64'(er));
      chk("model_out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("model_out_data", 64'(bus.out_data), 64'(m_data));
      chk("model_out_sel", 64'(bus.out_sel), 64'(m_sel));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input bit v, input int s, input logic [31:0] d);
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'(v));
    chk({nm, "_sel"}, 64'(bus.out_sel), 64'(s));
    chk({nm, "_data"}, 64'(bus.out_data), 64'(d));
  endtask

  int exp_stream[5];
  int exp_sparse[3];
  int exp_cfg[3];
  int cnt[NCH];

  initial begin
`ifdef ARB_MUX_FIXED_PRI_EN
    exp_stream = '{0, 0, 0, 0, 0};
    exp_sparse = '{0, 0, 0};
    exp_cfg    = '{1, 1, 1};
`else
    exp_stream = '{0, 1, 2, 3, 0};
    exp_sparse = '{0, 1, 0};
    exp_cfg    = '{1, 2, 1};
`endif
    for (int i = 0; i < NCH; i++) bus.in_data[i*WIDTH +: WIDTH] = lane_word(i);
    rst_f         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;

    // reset held two cycles with all requesters active
    cyc(); cyc();
    expect_out("reset", 1'b0, 0, 32'h0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'h0);

    rst_f = 1'b1;
    #1;
    chk("first_grant_ready", 64'(bus.in_ready), 64'b0001);

    // streaming, all channels requesting
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out("stream", 1'b1, exp_stream[i], lane_word(exp_stream[i]));
    end

    // grant 2 puts ptr at 3, then 0011 must wrap to 0
    bus.in_valid = 4'b0100;
    cyc();
    expect_out("sparse_pre", 1'b1, 2, lane_word(2));
    bus.in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("sparse", 1'b1, exp_sparse[i], lane_word(exp_sparse[i]));
    end

    // backpressure: held word frozen, then replaced with no bubble
    bus.out_ready = 1'b0;
    #1;
    chk("stall_in_ready", 64'(bus.in_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("stall", 1'b1, exp_sparse[2], lane_word(exp_sparse[2]));
    end
    bus.out_ready = 1'b1;
    cyc();
`ifdef ARB_MUX_FIXED_PRI_EN
    expect_out("unstall", 1'b1, 0, lane_word(0));
`else
    expect_out("unstall", 1'b1, 1, lane_word(1));
`endif

    // idle drains the register
    bus.in_valid = 4'b0000;
    cyc();
    chk("idle_valid", 64'(bus.out_valid), 64'h0);
    cyc();
    chk("idle_valid2", 64'(bus.out_valid), 64'h0);

    // reset while holding a stalled word
    bus.in_valid = 4'b0100;
    cyc();
    expect_out("pre_rst", 1'b1, 2, lane_word(2));
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    rst_f         = 1'b0;
    cyc();
    expect_out("mid_rst", 1'b0, 0, 32'h0);
    rst_f         = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_ptr0", 64'(bus.in_ready), 64'b0001);
    cyc();
    expect_out("post_rst", 1'b1, 0, lane_word(0));

`ifndef ARB_MUX_FIXED_PRI_EN
    // fairness: channels 1 and 3 requesting, 8 transfers
    bus.in_valid = 4'b1010;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.out_valid) cnt[bus.out_sel]++;
    end
    chk("fair_ch1", 64'(cnt[1]), 64'd4);
    chk("fair_ch3", 64'(cnt[3]), 64'd4);
    chk("fair_ch0", 64'(cnt[0]), 64'd0);
`endif

    // pointer back to 0, then channels 1 and 2 requesting
    rst_f        = 1'b0;
    bus.in_valid = 4'b0000;
    cyc();
    rst_f        = 1'b1;
    bus.in_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("cfg", 1'b1, exp_cfg[i], lane_word(exp_cfg[i]));
    end
    bus.in_valid = 4'b0000;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered N-channel multiplexer with valid/ready handshaking and round-robin arbitration. It generalises the datapath's 2:1 select to NCH sources of WIDTH bits. The select is computed internally from the requesters, not driven by the controller. Sits between multiple producers (e.g. ALU result, memory read, immediate path) and a single consumer register stage, with one cycle of latency and full throughput.

## Interface
- WIDTH, 32, data width per channel (≥1)
- NCH, 4, number of input channels (≥1)
- SELW, 2, width of channel index; must equal max(1, ceil(log2(NCH)))

- clk  input  1  rising-edge clock
- rst_f  input  1  reset: one clock, reset is synchronous and active-low
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i has a word to offer
- in_ready  output  NCH  channel i's word is accepted this cycle
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle
- out_sel  output  SELW  index of the channel that produced out_data

## Operation
- State:
  - output register (out_data, out_sel, out_valid);
  - round-robin pointer ptr (SELW bits, range 0..NCH-1).
- load = ~out_valid | out_ready. The output register may accept a new word when load is 1.
- Arbitration (combinational):
  - winner = first i with in_valid[i]=1, scanning ptr, ptr+1, … modulo NCH.
  - No valid input means no winner.
- in_ready[i] = load & winner_exists & (winner==i). At most one bit is set. in_ready never depends on in_valid[i] of the same channel other than through the arbitration.
- Transfer on input side: in_valid[w] & in_ready[w]. On that edge:
  - out_data ← in_data[w];
  - out_sel ← w;
  - out_valid ← 1;
  - ptr ← (w+1) mod NCH, wrapping NCH-1 → 0.
- Output side:
  - if out_valid & out_ready and no input transfer, then out_valid ← 0;
  - out_data and out_sel hold their last values.
- Simultaneous output consume and input transfer: the register is overwritten, out_valid stays 1, and there is no bubble.
- Stall (out_valid=1, out_ready=0): in_ready is all 0. out_data, out_sel and ptr are frozen.
- NCH=1: ptr is constant 0 and the block degenerates to a 1-deep pipeline register.
- Reset (rst_f=0 at a rising edge), regardless of state:
  - out_valid=0, out_data=0, out_sel=0, ptr=0;
  - any held word is discarded.
- in_ready is forced to 0 while rst_f=0.

## Timing
- Latency: an input accepted at edge n appears on out_data/out_valid after edge n, i.e. visible in cycle n+1.
- Throughput: one word per cycle when out_ready is held 1.
- in_ready is combinational from in_valid, ptr, out_valid and out_ready.
- out_* are purely registered.
- Fairness: under continuous requests from k channels, each channel is granted exactly once every k accepted transfers.

## Configuration
- ARB_MUX_FIXED_PRI_EN
  - Defined: arbitration is fixed priority and the lowest index wins. ptr is not implemented and out_sel behaviour is unchanged. The test bench's fairness checks are skipped.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset:
  - Stimulus: hold rst_f=0 for 2 cycles with in_valid=4'b1111.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000. After release, the first grant goes to channel 0.
- Round-robin streaming:
  - Stimulus: in_valid=4'b1111, out_ready=1, channel i data = 32'hA000_000i.
  - Required: out_sel sequence 0,1,2,3,0 with matching data, and out_valid continuously 1 from the cycle after the first grant.
- Sparse requests and wrap:
  - Stimulus: ptr=3 (after a grant to 2), in_valid=4'b0011.
  - Required: channel 0 granted, then channel 1, then channel 0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1.
  - Required: in_ready=0, out_data/out_sel stable. When out_ready returns to 1, the consumed word is replaced in the same edge with no bubble.
- Idle and reset mid-operation:
  - Stimulus: in_valid=0 while out_ready=1. Then assert rst_f=0 while out_valid=1 and out_ready=0.
  - Required: out_valid drops after one consume. The reset drops the held word (out_valid=0 next cycle) and ptr returns to 0.
- Configuration ARB_MUX_FIXED_PRI_EN:
  - Stimulus: in_valid=4'b0110 held for 3 transfers.
  - Required: out_sel=1 on all three.
